// File: rtl/block_check_sched_if.sv
// rtl/block_check_sched_if.sv - requester lanes, checker drive and result port of block_check_sched
// slave = scheduler side, master = requesters/checker/consumer side.
interface block_check_sched_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        chk_in;
  logic              chk_en;
  logic              chk_clr;
  logic              chk_result;
  logic              done_valid;
  logic              done_ready;
  logic [IDW-1:0]    done_id;
  logic              done_result;
  logic              done_err;

  modport slave (
    input  req_valid, req_data, req_last, chk_result, done_ready,
    output req_ready, chk_in, chk_en, chk_clr, done_valid, done_id, done_result, done_err
  );

  modport master (
    output req_valid, req_data, req_last, chk_result, done_ready,
    input  req_ready, chk_in, chk_en, chk_clr, done_valid, done_id, done_result, done_err
  );
endinterface

// File: rtl/block_check_sched.sv
// rtl/block_check_sched.sv - round-robin scheduler sharing one begin/end BlockChecker among NREQ sources
// Optional stall abort: define BCS_TIMEOUT_EN (limit = TIMEOUT cycles).
module block_check_sched #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  block_check_sched_if.slave    io_bus
);
  localparam int DW = IDW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FLUSH, S_SAMPLE, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [IDW-1:0] r_grant, r_rr_ptr, r_done_id;
  logic           r_done_result, r_done_err;
  logic           w_found;
  logic [IDW-1:0] w_pick, w_pick_inc;
  logic [DW-1:0]  w_dist, w_best;
  logic           w_cur_valid, w_cur_last;
  logic [7:0]     w_cur_data;
  logic           w_abort, w_err;

  if (NREQ < 2 || NREQ > 4 || IDW < $clog2(NREQ) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("block_check_sched: unsupported NREQ/IDW/TIMEOUT");
  end

  // Pick the valid lane with the smallest round-robin distance from r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = '0;
    w_dist  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (DW'(i) >= {1'b0, r_rr_ptr})
        w_dist = DW'(i) - {1'b0, r_rr_ptr};
      else
        w_dist = DW'(i + NREQ) - {1'b0, r_rr_ptr};
      if (io_bus.req_valid[i] && (!w_found || w_dist < w_best)) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_pick  = IDW'(i);
      end
    end
  end

  assign w_pick_inc  = (w_pick == IDW'(NREQ - 1)) ? '0 : w_pick + IDW'(1);
  assign w_cur_valid = io_bus.req_valid[r_grant];
  assign w_cur_last  = io_bus.req_last[r_grant];
  assign w_cur_data  = io_bus.req_data[8*r_grant +: 8];

`ifdef BCS_TIMEOUT_EN
  logic [7:0] r_stall_cnt;
  logic       r_abort;

  assign w_abort = (r_state == S_STREAM) && !w_cur_valid && (r_stall_cnt == 8'(TIMEOUT - 1));
  assign w_err   = r_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_abort     <= 1'b0;
    end else if (r_state != S_STREAM) begin
      r_stall_cnt <= '0;
      if (r_state == S_CLEAR) r_abort <= 1'b0;
    end else if (w_cur_valid) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
      if (w_abort) r_abort <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_STREAM;
      S_STREAM: begin
        if (w_cur_valid && w_cur_last) w_next = S_FLUSH;
        else if (w_abort)              w_next = S_SAMPLE;
      end
      S_FLUSH:  w_next = S_SAMPLE;
      S_SAMPLE: w_next = S_DONE;
      S_DONE:   if (io_bus.done_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The trailing space in FLUSH terminates the final word so "end" is seen.
  always_comb begin
    io_bus.req_ready  = '0;
    io_bus.chk_in     = '0;
    io_bus.chk_en     = 1'b0;
    io_bus.chk_clr    = 1'b0;
    io_bus.done_valid = (r_state == S_DONE);
    case (r_state)
      S_CLEAR:  io_bus.chk_clr = 1'b1;
      S_STREAM: begin
        io_bus.req_ready = NREQ'(1) << r_grant;
        io_bus.chk_in    = w_cur_data;
        io_bus.chk_en    = w_cur_valid;
      end
      S_FLUSH: begin
        io_bus.chk_in = 8'h20;
        io_bus.chk_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_done_id     <= '0;
      r_done_result <= 1'b0;
      r_done_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant  <= w_pick;
        r_rr_ptr <= w_pick_inc;
      end
      if (r_state == S_SAMPLE) begin
        r_done_id     <= r_grant;
        r_done_result <= io_bus.chk_result & ~w_err;
        r_done_err    <= w_err;
      end
    end
  end

  assign io_bus.done_id     = r_done_id;
  assign io_bus.done_result = r_done_result;
  assign io_bus.done_err    = r_done_err;
endmodule

// File: tb/tb_block_check_sched.sv
// tb/tb_block_check_sched.sv - scoreboard bench for block_check_sched with a begin/end checker model
module tb_block_check_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_pass   = 0;
  int cnt_clr = 0, cnt_en = 0, cnt_space = 0;

  typedef struct { int id; bit res; bit err; } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  typedef struct { int lane; string msg; int gap_at; int gap_len; bit res; } vec_t;
  vec_t tbl[6];
  logic [4:0] seq_exp [13];

  block_check_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  block_check_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // Checker model: case-insensitive words split on space, begin/end must nest and balance.
  int         m_depth = 0;
  bit         m_bad   = 1'b0;
  int         m_len   = 0;
  logic [39:0] m_word = '0;

  always @(posedge clk) begin
    logic [7:0] c;
    c = bus.chk_in;
    if (c >= 8'h41 && c <= 8'h5a) c = c + 8'h20;
    if (bus.chk_clr) begin
      m_depth <= 0; m_bad <= 1'b0; m_len <= 0; m_word <= '0;
    end else if (bus.chk_en) begin
      if (c == 8'h20) begin
        if (m_len == 5 && m_word == "begin") m_depth <= m_depth + 1;
        else if (m_len == 3 && m_word[23:0] == "end") begin
          if (m_depth == 0) m_bad <= 1'b1;
          else              m_depth <= m_depth - 1;
        end
        m_len  <= 0;
        m_word <= '0;
      end else begin
        m_word <= {m_word[31:0], c};
        m_len  <= m_len + 1;
      end
    end
  end

  assign bus.chk_result = !m_bad && (m_depth == 0);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.chk_clr) cnt_clr++;
      if (bus.chk_en) begin
        cnt_en++;
        if (bus.chk_in == 8'h20) cnt_space++;
      end
      if (bus.done_valid && bus.done_ready) begin
        if (sb.size() == 0) check("unexpected done", 32'd1, 32'd0);
        else begin
          e_mon = sb.pop_front();
          check("done_id", 32'(bus.done_id), 32'(e_mon.id));
          check("done_result", 32'(bus.done_result), 32'(e_mon.res));
          check("done_err", 32'(bus.done_err), 32'(e_mon.err));
        end
      end
    end
  end

  task automatic drive_byte(int lane, byte c, bit last);
    int t = 0;
    bus.req_valid[lane]        = 1'b1;
    bus.req_data[8*lane +: 8]  = c;
    bus.req_last[lane]         = last;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[lane] && t < 300);
    if (!bus.req_ready[lane]) check($sformatf("ready wait lane%0d", lane), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(int lane, string msg, int gap_at, int gap_len);
    for (int i = 0; i < msg.len(); i++) begin
      if (i == gap_at) begin
        bus.req_valid[lane] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      drive_byte(lane, msg[i], i == msg.len() - 1);
    end
    bus.req_valid[lane] = 1'b0;
    bus.req_last[lane]  = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({name, " drain"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int clr0, en0, sp0, nsp;
    string part;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus.done_ready = 1'b1;

    tbl[0] = '{0, "begin end",           -1, 0, 1'b1};
    tbl[1] = '{1, "begin",               -1, 0, 1'b0};
    tbl[2] = '{0, "BEgin end",            2, 5, 1'b1};
    tbl[3] = '{1, "x",                   -1, 0, 1'b1};
    tbl[4] = '{0, "begin begin end end", -1, 0, 1'b1};
    tbl[5] = '{1, "end begin",           -1, 0, 1'b0};

    seq_exp = '{5'b00000, 5'b10000, 5'b00110, 5'b00010, 5'b00000, 5'b00001, 5'b00001,
                5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b10000, 5'b01010};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",   32'(bus.req_ready),   32'd0);
    check("rst chk_in",      32'(bus.chk_in),      32'd0);
    check("rst chk_en",      32'(bus.chk_en),      32'd0);
    check("rst chk_clr",     32'(bus.chk_clr),     32'd0);
    check("rst done_valid",  32'(bus.done_valid),  32'd0);
    check("rst done_id",     32'(bus.done_id),     32'd0);
    check("rst done_result", 32'(bus.done_result), 32'd0);
    check("rst done_err",    32'(bus.done_err),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both lanes valid at reset exit; lane0's second message must wait behind lane1.
    sb.push_back('{0, 1'b1, 1'b0});
    sb.push_back('{1, 1'b0, 1'b0});
    sb.push_back('{0, 1'b0, 1'b0});
    fork
      begin
        send(0, "begin end", -1, 0);
        send(0, "end", -1, 0);
      end
      send(1, "begin", -1, 0);
    join
    wait_drain("round robin");

    // Cycle-exact latency, done hold with done_ready low, lane1 waiting meanwhile.
    bus.done_ready      = 1'b0;
    bus.req_valid[0]    = 1'b1;
    bus.req_data[7:0]   = "A";
    bus.req_last[0]     = 1'b1;
    sb.push_back('{0, 1'b1, 1'b0});
    sb.push_back('{1, 1'b1, 1'b0});
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check($sformatf("seq N%0d clr/ready/en/dv", k),
            32'({bus.chk_clr, bus.req_ready, bus.chk_en, bus.done_valid}), 32'(seq_exp[k]));
      if (k == 3) check("flush chk_in", 32'(bus.chk_in), 32'h20);
      if (k >= 5 && k <= 9) begin
        check($sformatf("hold N%0d done_id", k), 32'(bus.done_id), 32'd0);
        check($sformatf("hold N%0d done_result", k), 32'(bus.done_result), 32'd1);
      end
      if (k == 2) begin
        @(posedge clk); #1;
        bus.req_valid[0]   = 1'b0;
        bus.req_last[0]    = 1'b0;
        bus.req_valid[1]   = 1'b1;
        bus.req_data[15:8] = "B";
        bus.req_last[1]    = 1'b1;
      end
      if (k == 8) begin
        @(posedge clk); #1;
        bus.done_ready = 1'b1;
      end
      if (k == 12) begin
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        bus.req_last[1]  = 1'b0;
      end
    end
    wait_drain("latency");

    for (int v = 0; v < 6; v++) begin
      clr0 = cnt_clr; en0 = cnt_en; sp0 = cnt_space;
      nsp = 0;
      for (int i = 0; i < tbl[v].msg.len(); i++) if (tbl[v].msg[i] == 8'h20) nsp++;
      sb.push_back('{tbl[v].lane, tbl[v].res, 1'b0});
      send(tbl[v].lane, tbl[v].msg, tbl[v].gap_at, tbl[v].gap_len);
      wait_drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d clr pulses", v), 32'(cnt_clr - clr0), 32'd1);
      check($sformatf("vec%0d chk_en cycles", v), 32'(cnt_en - en0), 32'(tbl[v].msg.len() + 1));
      check($sformatf("vec%0d spaces", v), 32'(cnt_space - sp0), 32'(nsp + 1));
    end

    // Abandon a message after "begin " so an uncleared checker would balance a later "end".
    part = "begin ";
    for (int i = 0; i < part.len(); i++) drive_byte(0, part[i], 1'b0);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge clk);
    check("midrst done_valid", 32'(bus.done_valid), 32'd0);
    check("midrst done_id",    32'(bus.done_id),    32'd0);
    check("midrst req_ready",  32'(bus.req_ready),  32'd0);
    check("midrst chk_en",     32'(bus.chk_en),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back('{0, 1'b0, 1'b0});
    sb.push_back('{1, 1'b1, 1'b0});
    fork
      send(0, "end", -1, 0);
      send(1, "begin end", -1, 0);
    join
    wait_drain("after reset");

`ifdef BCS_TIMEOUT_EN
    sb.push_back('{0, 1'b0, 1'b1});
    drive_byte(0, "b", 1'b0);
    bus.req_valid[0] = 1'b0;
    wait_drain("timeout");
    sb.push_back('{0, 1'b1, 1'b0});
    send(0, "x", -1, 0);
    wait_drain("after timeout");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
